door_lock_controller: RTL and testbench

- Sequential controller for the smart-room door lock. Collects keypad digits one at a time, checks the entered code against a stored code, and drives a timed unlock pulse.
- Counts failed attempts and imposes a lockout after too many. Supports reprogramming the stored code while the security system is switched off.
- Sits between the keypad scanner and the door actuator.

---
 rtl/door_lock_controller_if.sv | 26 ++
 rtl/door_lock_controller.sv | 140 ++++++++++++++
 tb/tb_door_lock_controller.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/door_lock_controller_if.sv
// door_lock_controller_if: keypad-side inputs and actuator-side outputs of the door lock controller.
// Latency: none (plain wires). Backpressure: none, all keypad signals are one-cycle strobes.
// Ports: master = keypad scanner / supervisor, slave = door_lock_controller.
interface door_lock_controller_if;
  logic       switch;      // 1 = armed, 0 = program mode
  logic       key_valid;   // strobe: key_digit valid
  logic [3:0] key_digit;   // BCD digit, 10..15 dropped
  logic       key_enter;   // strobe: submit entry
  logic       key_clear;   // strobe: discard entry
  logic       unlock;      // door open pulse
  logic       fail;        // strobe on wrong code
  logic       locked_out;  // high during lockout
  logic       alarm;       // alarm drive
  logic [1:0] fail_cnt;    // consecutive failures
  logic [2:0] digit_cnt;   // digits buffered

  modport master (
    output switch, key_valid, key_digit, key_enter, key_clear,
    input  unlock, fail, locked_out, alarm, fail_cnt, digit_cnt
  );

  modport slave (
    input  switch, key_valid, key_digit, key_enter, key_clear,
    output unlock, fail, locked_out, alarm, fail_cnt, digit_cnt
  );
endinterface

// File: rtl/door_lock_controller.sv
// door_lock_controller: collects keypad digits, checks them against a stored code, drives a timed unlock,
// counts failures into a timed lockout, and reprograms the code while disarmed.
// Latency: key_enter at N -> verdict at N+1 -> unlock/locked_out from N+2. No backpressure: keys arriving
// outside IDLE/ENTRY are dropped.
// Ports: clk, rst_n (async, active-low), bus (slave modport of door_lock_controller_if).
// Optional: define DOOR_ALARM_EN to drive alarm during lockout and alongside each fail pulse; otherwise alarm=0.
module door_lock_controller #(
  parameter int                  DIGITS         = 4,
  parameter logic [4*DIGITS-1:0] DEFAULT_CODE   = 16'h1473,
  parameter int                  MAX_FAIL       = 3,
  parameter int                  UNLOCK_CYCLES  = 50,
  parameter int                  LOCKOUT_CYCLES = 200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  door_lock_controller_if.slave bus
);
  localparam int CW   = 4 * DIGITS;
  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  // Timer is loaded with N-1 and the state exits on zero, giving exactly N cycles.
  localparam logic [TW-1:0] T_UNLOCK = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK   = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]    CNT_FULL = 3'(DIGITS);
  localparam logic [1:0]    FAIL_MAX = 2'(MAX_FAIL);

  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, PROG, LOCKOUT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] code, code_nxt;
  logic [CW-1:0] entry, entry_nxt;
  logic [2:0]    digit_cnt, digit_cnt_nxt;
  logic [1:0]    fail_cnt, fail_cnt_nxt, fail_inc;
  logic [TW-1:0] timer, timer_nxt;
  logic          digit_ok, code_match, fail_pulse;

  assign digit_ok   = bus.key_valid && (bus.key_digit <= 4'd9) && (digit_cnt < CNT_FULL);
  assign code_match = (digit_cnt == CNT_FULL) && (entry == code);
  assign fail_inc   = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      code      <= DEFAULT_CODE;
      entry     <= '0;
      digit_cnt <= '0;
      fail_cnt  <= '0;
      timer     <= '0;
    end else begin
      state     <= state_nxt;
      code      <= code_nxt;
      entry     <= entry_nxt;
      digit_cnt <= digit_cnt_nxt;
      fail_cnt  <= fail_cnt_nxt;
      timer     <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    code_nxt      = code;
    entry_nxt     = entry;
    digit_cnt_nxt = digit_cnt;
    fail_cnt_nxt  = fail_cnt;
    timer_nxt     = timer;
    fail_pulse    = 1'b0;
    case (state)
      IDLE, ENTRY: begin
        if (bus.key_clear) begin
          entry_nxt     = '0;
          digit_cnt_nxt = '0;
          state_nxt     = IDLE;
        end else begin
          if (digit_ok) begin
            entry_nxt     = {entry[CW-5:0], bus.key_digit};
            digit_cnt_nxt = digit_cnt + 3'd1;
            state_nxt     = ENTRY;
          end
          // A same-cycle digit lands in the buffer on this edge, so CHECK/PROG already sees it.
          // Enter with nothing buffered and no digit this cycle is a no-op.
          if (bus.key_enter && (digit_ok || state == ENTRY)) begin
            state_nxt = bus.switch ? CHECK : PROG;
          end
        end
      end
      CHECK: begin
        entry_nxt     = '0;
        digit_cnt_nxt = '0;
        if (code_match) begin
          state_nxt    = OPEN;
          timer_nxt    = T_UNLOCK;
          fail_cnt_nxt = '0;
        end else begin
          fail_pulse   = 1'b1;
          fail_cnt_nxt = fail_inc;
          if (fail_inc == FAIL_MAX) begin
            state_nxt = LOCKOUT;
            timer_nxt = T_LOCK;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      OPEN: begin
        if (timer == '0) state_nxt = IDLE;
        else             timer_nxt = timer - TW'(1);
      end
      PROG: begin
        if (digit_cnt == CNT_FULL) code_nxt = entry;
        entry_nxt     = '0;
        digit_cnt_nxt = '0;
        fail_cnt_nxt  = '0;
        state_nxt     = IDLE;
      end
      LOCKOUT: begin
        // fail_cnt stays at its saturated value for the whole lockout.
        if (timer == '0) begin
          state_nxt    = IDLE;
          fail_cnt_nxt = '0;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode straight from state so reset clears them asynchronously.
  assign bus.unlock     = (state == OPEN);
  assign bus.locked_out = (state == LOCKOUT);
  assign bus.fail       = fail_pulse;
  assign bus.fail_cnt   = fail_cnt;
  assign bus.digit_cnt  = digit_cnt;

`ifdef DOOR_ALARM_EN
  assign bus.alarm = (state == LOCKOUT) || fail_pulse;
`else
  assign bus.alarm = 1'b0;
`endif
endmodule

// File: tb/tb_door_lock_controller.sv
// tb_door_lock_controller: directed and random keypad sequences against a digit-list reference model;
// expected fail/unlock/lockout events are queued at stimulus time and popped by a negedge monitor.
// Ports: none (top-level bench); drives door_lock_controller through door_lock_controller_if.
module tb_door_lock_controller;
  localparam int UNLOCK = 50;
  localparam int LOCK   = 200;
`ifdef DOOR_ALARM_EN
  localparam bit ALARM_EN = 1'b1;
`else
  localparam bit ALARM_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;

  door_lock_controller_if bus();
  door_lock_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: stored code and entry as digit lists, failure count as an integer.
  typedef struct {int k; int fcnt; int len;} ev_t;
  ev_t fail_q[$], open_q[$], lock_q[$];
  int  mcode[4];
  int  entry[$];
  int  mfail       = 0;
  int  ready       = 0;
  int  last_k      = 0;
  int  open_len    = UNLOCK;
  int  exp_fail_at = -1;
  int  lock_from   = -1;
  int  lock_to     = -2;

  task automatic wait_ready();
    while (cyc < ready) @(negedge clk);
  endtask

  function automatic void model_digit(input int d);
    if (d <= 9 && entry.size() < 4) entry.push_back(d);
  endfunction

  task automatic key(input int d);
    wait_ready();
    model_digit(d);
    bus.key_valid = 1'b1;
    bus.key_digit = 4'(d);
    @(negedge clk);
    bus.key_valid = 1'b0;
    check("digit_cnt", bus.digit_cnt, entry.size());
  endtask

  task automatic clear(input bit with_digit);
    wait_ready();
    entry.delete();
    bus.key_clear = 1'b1;
    bus.key_valid = with_digit;
    bus.key_digit = 4'd5;
    @(negedge clk);
    bus.key_clear = 1'b0;
    bus.key_valid = 1'b0;
    check("clear_digit_cnt", bus.digit_cnt, 0);
  endtask

  // Keys sent while the controller is busy; the model does not see them.
  task automatic poke(input bit is_enter, input int d);
    bus.key_valid = !is_enter;
    bus.key_enter = is_enter;
    bus.key_digit = 4'(d);
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_enter = 1'b0;
  endtask

  task automatic submit(input bit sw, input bit with_digit, input int d);
    bit  ok;
    ev_t ev;
    wait_ready();
    last_k = cyc;
    if (with_digit) model_digit(d);
    ready = cyc;
    if (entry.size() > 0) begin
      ev.k = cyc; ev.fcnt = 0; ev.len = 0;
      if (sw) begin
        ok = (entry.size() == 4);
        if (ok) for (int i = 0; i < 4; i++) if (entry[i] != mcode[i]) ok = 1'b0;
        if (ok) begin
          mfail  = 0;
          ev.len = open_len;
          open_q.push_back(ev);
          ready = cyc + 2 + UNLOCK;
        end else begin
          mfail++;
          ev.fcnt = mfail;
          fail_q.push_back(ev);
          exp_fail_at = cyc + 1;
          if (mfail == 3) begin
            ev.len = LOCK;
            lock_q.push_back(ev);
            lock_from = cyc + 2;
            lock_to   = cyc + 1 + LOCK;
            mfail     = 0;
            ready     = cyc + 2 + LOCK;
          end else begin
            ready = cyc + 2;
          end
        end
      end else begin
        if (entry.size() == 4) for (int i = 0; i < 4; i++) mcode[i] = entry[i];
        mfail = 0;
        ready = cyc + 2;
      end
      entry.delete();
    end
    bus.switch    = sw;
    bus.key_enter = 1'b1;
    bus.key_valid = with_digit;
    bus.key_digit = 4'(d);
    @(negedge clk);
    bus.key_enter = 1'b0;
    bus.key_valid = 1'b0;
  endtask

  task automatic check_idle();
    wait_ready();
    check("idle_digit_cnt", bus.digit_cnt, entry.size());
    check("idle_fail_cnt", bus.fail_cnt, mfail);
    check("idle_unlock", bus.unlock, 0);
    check("idle_locked_out", bus.locked_out, 0);
  endtask

  task automatic code_keys(input int a, input int b, input int c, input int d);
    key(a); key(b); key(c); key(d);
  endtask

  // Monitor: pops expected events whenever the DUT presents one.
  bit pu = 1'b0, pl = 1'b0, pend = 1'b0;
  int us = 0, ls = 0, pend_exp = 0;
  always @(negedge clk) begin
    ev_t ev;
    bit  exp_alarm;
    if (pend) begin
      check("fail_cnt_after_fail", bus.fail_cnt, pend_exp);
      pend = 1'b0;
    end
    if (bus.fail) begin
      check("fail_expected", fail_q.size() > 0, 1);
      if (fail_q.size() > 0) begin
        ev = fail_q.pop_front();
        check("fail_latency", cyc - ev.k, 1);
        pend = 1'b1;
        pend_exp = ev.fcnt;
      end
    end
    if (bus.unlock && !pu) us = cyc;
    if (!bus.unlock && pu) begin
      check("open_expected", open_q.size() > 0, 1);
      if (open_q.size() > 0) begin
        ev = open_q.pop_front();
        check("unlock_latency", us - ev.k, 2);
        check("unlock_len", cyc - us, ev.len);
      end
    end
    if (bus.locked_out && !pl) ls = cyc;
    if (!bus.locked_out && pl) begin
      check("lock_expected", lock_q.size() > 0, 1);
      if (lock_q.size() > 0) begin
        ev = lock_q.pop_front();
        check("lockout_latency", ls - ev.k, 2);
        check("lockout_len", cyc - ls, ev.len);
      end
    end
    pu = bus.unlock;
    pl = bus.locked_out;
    exp_alarm = ALARM_EN && ((cyc == exp_fail_at) || (cyc >= lock_from && cyc <= lock_to));
    check("alarm", bus.alarm, exp_alarm);
  end

  initial begin
    int n, d;
    bit use_code;
    mcode = '{1, 4, 7, 3};
    bus.switch = 1'b1; bus.key_valid = 1'b0; bus.key_digit = 4'd0;
    bus.key_enter = 1'b0; bus.key_clear = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_unlock", bus.unlock, 0);
    check("rst_fail", bus.fail, 0);
    check("rst_locked_out", bus.locked_out, 0);
    check("rst_alarm", bus.alarm, 0);
    check("rst_fail_cnt", bus.fail_cnt, 0);
    check("rst_digit_cnt", bus.digit_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready = cyc;

    // Correct code; disarming mid-unlock must not shorten it.
    code_keys(1, 4, 7, 3); submit(1, 0, 0);
    repeat (5) @(negedge clk); bus.switch = 1'b0;
    check_idle();
    // Single wrong code.
    code_keys(1, 5, 6, 2); submit(1, 0, 0); check_idle();
    // Reach lockout; correct code and disarm during lockout have no effect.
    code_keys(0, 0, 0, 0); submit(1, 0, 0); check_idle();
    code_keys(9, 9, 9, 9); submit(1, 0, 0);
    repeat (3) @(negedge clk);
    bus.switch = 1'b0;
    poke(0, 1); poke(0, 4); poke(0, 7); poke(0, 3); poke(1, 0);
    check("lockout_digit_cnt", bus.digit_cnt, 0);
    check("lockout_held", bus.locked_out, 1);
    check_idle();
    code_keys(1, 4, 7, 3); submit(1, 0, 0); check_idle();
    // Clear, fifth digit, non-BCD digit, short entry.
    key(1); key(4); clear(0);
    code_keys(1, 4, 7, 3); submit(1, 0, 0); check_idle();
    code_keys(1, 4, 7, 3); key(5); submit(1, 0, 0); check_idle();
    key(1); key(4); key(11); key(7); key(3); submit(1, 0, 0); check_idle();
    key(1); key(4); key(7); submit(1, 0, 0); check_idle();
    // Same-cycle digit + enter, clear beating a same-cycle digit, empty enter.
    key(1); key(4); key(7); submit(1, 1, 3); check_idle();
    key(9); clear(1);
    code_keys(1, 4, 7, 3); submit(1, 0, 0); check_idle();
    submit(1, 0, 0); check_idle();
    // Reprogramming.
    code_keys(2, 5, 8, 0); submit(0, 0, 0); check_idle();
    code_keys(1, 4, 7, 3); submit(1, 0, 0); check_idle();
    code_keys(2, 5, 8, 0); submit(1, 0, 0); check_idle();
    key(1); key(2); key(3); submit(0, 0, 0); check_idle();
    code_keys(2, 5, 8, 0); submit(1, 0, 0); check_idle();
    // Reset 20 cycles into an unlock.
    open_len = 20;
    code_keys(2, 5, 8, 0); submit(1, 0, 0);
    open_len = UNLOCK;
    do begin @(posedge clk); #1; end while (cyc < last_k + 22);
    rst_n = 1'b0;
    #1;
    check("rst_mid_unlock", bus.unlock, 0);
    check("rst_mid_fail_cnt", bus.fail_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mcode = '{1, 4, 7, 3}; mfail = 0; entry.delete(); ready = cyc;
    code_keys(1, 4, 7, 3); submit(1, 0, 0); check_idle();

    // Random sequences.
    for (int it = 0; it < 50; it++) begin
      n = $urandom_range(0, 5);
      use_code = ($urandom_range(0, 1) == 1);
      for (int j = 0; j < n; j++) begin
        if (use_code && j < 4) d = mcode[j];
        else d = $urandom_range(0, 9);
        if ($urandom_range(0, 9) == 0) key($urandom_range(10, 15));
        key(d);
      end
      if ($urandom_range(0, 9) == 0) clear($urandom_range(0, 1) == 1);
      submit($urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 12));
      check_idle();
    end

    repeat (5) @(negedge clk);
    check("queues_drained", fail_q.size() + open_q.size() + lock_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
